// File: rtl/pi_bus_pkg.sv
// Shared widths, default timing constants and FSM encoding for the PI-to-PET bus controller.
package pi_bus_pkg;
    localparam int PI_ADDR_W          = 17;
    localparam int PI_DATA_W          = 8;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_WAIT_STATES    = 2;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SLOT,
        ADDR,
        STROBE,
        RELEASE,
        DONE
    } state_t;
endpackage

// File: rtl/sync_n.sv
// Multi-flop synchronizer for a single-bit level crossing into the clk domain.
module sync_n #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_reg <= '0;
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], d};
        end
    end

    assign q = chain_reg[STAGES-1];
endmodule

// File: rtl/pi_bus_ctl.sv
// Executes one pi_com read/write per four-phase handshake on the shared PET memory bus.
// Optional slot-wait timeout is compiled in when PI_BUS_TIMEOUT_EN is defined.
module pi_bus_ctl
    import pi_bus_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int WAIT_STATES    = DEF_WAIT_STATES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [PI_ADDR_W-1:0] pi_addr,
    input  logic [PI_DATA_W-1:0] pi_data_in,
    input  logic                 pi_rw_b,
    input  logic                 pi_pending,
    output logic                 pi_done,
    output logic [PI_DATA_W-1:0] pi_rd_data,
    output logic                 pi_err,
    input  logic                 bus_slot,
    output logic [PI_ADDR_W-1:0] bus_addr,
    output logic [PI_DATA_W-1:0] bus_data_out,
    output logic                 bus_data_oe,
    input  logic [PI_DATA_W-1:0] bus_data_in,
    output logic                 ram_oe_n,
    output logic                 ram_we_n
);
    localparam int WS_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    logic                 pend_s;
    state_t               state_reg, state_next;
    logic [WS_W-1:0]      ws_cnt_reg, ws_cnt_next;
    logic                 ws_last;
    logic                 capture;
    logic                 timed_out;

    logic [PI_ADDR_W-1:0] req_addr_reg;
    logic [PI_DATA_W-1:0] req_data_reg;
    logic                 req_rw_reg;

    logic                 done_reg, done_next;
    logic [PI_DATA_W-1:0] rd_data_reg, rd_data_next;
    logic [PI_ADDR_W-1:0] addr_reg, addr_next;
    logic [PI_DATA_W-1:0] dout_reg, dout_next;
    logic                 oe_reg, oe_next;
    logic                 oe_n_reg, oe_n_next;
    logic                 we_n_reg, we_n_next;

    sync_n #(.STAGES(SYNC_STAGES)) u_pend_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pi_pending),
        .q       (pend_s)
    );

    assign ws_last = (ws_cnt_reg == WS_W'(WAIT_STATES - 1));

`ifdef PI_BUS_TIMEOUT_EN
    localparam int TO_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TO_W    = (TO_BITS > 12) ? TO_BITS : 12;

    logic [TO_W-1:0] to_cnt_reg;
    logic            err_reg, err_next;

    // Counts cycles spent in WAIT_SLOT; restarts on every entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_reg <= '0;
        end else if (state_reg == WAIT_SLOT) begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
        end else begin
            to_cnt_reg <= '0;
        end
    end

    assign timed_out = (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        err_next = 1'b0;
        if (state_next == DONE) begin
            err_next = err_reg | (state_reg == WAIT_SLOT);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign pi_err = err_reg;
`else
    assign timed_out = 1'b0;
    // No timeout hardware in this build; the limit parameter has no effect.
    assign pi_err    = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_next  = state_reg;
        ws_cnt_next = ws_cnt_reg;
        capture     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pend_s && !done_reg) begin
                    capture    = 1'b1;
                    state_next = WAIT_SLOT;
                end
            end
            WAIT_SLOT: begin
                if (!pend_s) begin
                    state_next = IDLE;
                end else if (bus_slot) begin
                    state_next = ADDR;
                end else if (timed_out) begin
                    state_next = DONE;
                end
            end
            ADDR: begin
                ws_cnt_next = '0;
                state_next  = STROBE;
            end
            STROBE: begin
                if (ws_last) begin
                    state_next = RELEASE;
                end else begin
                    ws_cnt_next = ws_cnt_reg + 1'b1;
                end
            end
            RELEASE: begin
                state_next = pend_s ? DONE : IDLE;
            end
            DONE: begin
                if (!pend_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus-side outputs are registered from state_next so strobes are glitch-free
    // and line up exactly with the STROBE state.
    always_comb begin
        addr_next    = addr_reg;
        dout_next    = dout_reg;
        rd_data_next = rd_data_reg;
        if (state_next == ADDR) begin
            addr_next = req_addr_reg;
            if (!req_rw_reg) begin
                dout_next = req_data_reg;
            end
        end
        if (state_reg == STROBE && ws_last && req_rw_reg) begin
            rd_data_next = bus_data_in;
        end
        oe_next   = !req_rw_reg && (state_next == ADDR || state_next == STROBE);
        oe_n_next = !(req_rw_reg && state_next == STROBE);
        we_n_next = !(!req_rw_reg && state_next == STROBE);
        done_next = (state_next == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            ws_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            ws_cnt_reg <= ws_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_addr_reg <= '0;
            req_data_reg <= '0;
            req_rw_reg   <= 1'b0;
            done_reg     <= 1'b0;
            rd_data_reg  <= '0;
            addr_reg     <= '0;
            dout_reg     <= '0;
            oe_reg       <= 1'b0;
            oe_n_reg     <= 1'b1;
            we_n_reg     <= 1'b1;
        end else begin
            if (capture) begin
                req_addr_reg <= pi_addr;
                req_data_reg <= pi_data_in;
                req_rw_reg   <= pi_rw_b;
            end
            done_reg    <= done_next;
            rd_data_reg <= rd_data_next;
            addr_reg    <= addr_next;
            dout_reg    <= dout_next;
            oe_reg      <= oe_next;
            oe_n_reg    <= oe_n_next;
            we_n_reg    <= we_n_next;
        end
    end

    assign pi_done      = done_reg;
    assign pi_rd_data   = rd_data_reg;
    assign bus_addr     = addr_reg;
    assign bus_data_out = dout_reg;
    assign bus_data_oe  = oe_reg;
    assign ram_oe_n     = oe_n_reg;
    assign ram_we_n     = we_n_reg;
endmodule

// File: tb/tb_pi_bus_ctl.sv
// Directed bench for pi_bus_ctl: table of complete accesses plus abort, reset and timeout sequences.
module tb_pi_bus_ctl;
    import pi_bus_pkg::*;

    localparam int SS = 2;
    localparam int WS = 2;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [16:0] pi_addr = '0;
    logic [7:0]  pi_data_in = '0;
    logic        pi_rw_b = 1'b0;
    logic        pi_pending = 1'b0;
    logic        pi_done;
    logic [7:0]  pi_rd_data;
    logic        pi_err;
    logic        bus_slot = 1'b0;
    logic [16:0] bus_addr;
    logic [7:0]  bus_data_out;
    logic        bus_data_oe;
    logic [7:0]  bus_data_in = '0;
    logic        ram_oe_n;
    logic        ram_we_n;

    always #5 clk = ~clk;

    pi_bus_ctl #(
        .SYNC_STAGES    (SS),
        .WAIT_STATES    (WS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pi_addr      (pi_addr),
        .pi_data_in   (pi_data_in),
        .pi_rw_b      (pi_rw_b),
        .pi_pending   (pi_pending),
        .pi_done      (pi_done),
        .pi_rd_data   (pi_rd_data),
        .pi_err       (pi_err),
        .bus_slot     (bus_slot),
        .bus_addr     (bus_addr),
        .bus_data_out (bus_data_out),
        .bus_data_oe  (bus_data_oe),
        .bus_data_in  (bus_data_in),
        .ram_oe_n     (ram_oe_n),
        .ram_we_n     (ram_we_n)
    );

    int total = 0;
    int bad = 0;
    int viol = 0;

    // Bus invariants watched continuously.
    always @(negedge clk) begin
        if (reset_n) begin
            if (!ram_oe_n && !ram_we_n) viol++;
            if (!ram_oe_n && bus_data_oe) viol++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rw;
        logic [16:0] addr;
        logic [7:0]  wd;
        logic [7:0]  bin;
        int          dly;
        int          hold;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs[5];

    // One complete access; dly is the number of clocks after pending rises before bus_slot
    // (>= SS+1), hold keeps pending high that many clocks in DONE with bus_slot every 8 clk.
    task automatic do_access(input vec_t v);
        int early;
        int hold_bad;
        early    = 0;
        hold_bad = 0;
        pi_rw_b     = v.rw;
        pi_addr     = v.addr;
        pi_data_in  = v.wd;
        bus_data_in = v.bin;
        pi_pending  = 1'b1;
        for (int i = 0; i < v.dly; i++) begin
            tick();
            if (!ram_oe_n || !ram_we_n || bus_data_oe || pi_done) early++;
        end
        chk("quiet_before_slot", early, 0);
        bus_slot = 1'b1;
        tick();
        bus_slot = 1'b0;
        chk("addr_phase_addr", bus_addr, v.addr);
        chk("addr_phase_ctl", {ram_oe_n, ram_we_n, bus_data_oe}, {1'b1, 1'b1, !v.rw});
        for (int k = 0; k < WS; k++) begin
            tick();
            chk("strobe_ctl", {ram_oe_n, ram_we_n, bus_data_oe}, {!v.rw, v.rw, !v.rw});
            if (!v.rw) chk("strobe_wdata", bus_data_out, v.wd);
        end
        tick();
        chk("release_ctl", {ram_oe_n, ram_we_n, bus_data_oe, pi_done}, 4'b1100);
        chk("release_addr", bus_addr, v.addr);
        tick();
        chk("done_flags", {pi_done, pi_err}, 2'b10);
        chk("done_rd_data", pi_rd_data, v.exp_rd);
        for (int i = 1; i <= v.hold; i++) begin
            bus_slot = (i % 8 == 0);
            tick();
            if (!ram_oe_n || !ram_we_n || !pi_done) hold_bad++;
        end
        bus_slot = 1'b0;
        if (v.hold > 0) chk("hold_no_restart", hold_bad, 0);
        pi_pending = 1'b0;
        tick();
        tick();
        chk("done_held_during_sync", pi_done, 1'b1);
        tick();
        chk("done_fall", pi_done, 1'b0);
        chk("rd_data_after", pi_rd_data, v.exp_rd);
        $display("xact %s addr=%05h wd=%02h rd=%02h done", v.rw ? "RD" : "WR", v.addr, v.wd, pi_rd_data);
    endtask

    initial begin
        int cnt;
        vec_t v;

        vecs[0] = '{rw: 1'b0, addr: 17'h15581, wd: 8'h7e, bin: 8'h00, dly: 10, hold: 0,  exp_rd: 8'h00};
        vecs[1] = '{rw: 1'b1, addr: 17'h08000, wd: 8'h00, bin: 8'hA5, dly: 4,  hold: 24, exp_rd: 8'hA5};
        vecs[2] = '{rw: 1'b0, addr: 17'h1FFFF, wd: 8'hFF, bin: 8'h3C, dly: 8,  hold: 0,  exp_rd: 8'hA5};
        vecs[3] = '{rw: 1'b1, addr: 17'h00000, wd: 8'h11, bin: 8'h5A, dly: 3,  hold: 0,  exp_rd: 8'h5A};
        vecs[4] = '{rw: 1'b0, addr: 17'h00001, wd: 8'h01, bin: 8'hC3, dly: 5,  hold: 0,  exp_rd: 8'h5A};

        repeat (3) tick();
        chk("reset_outputs", {pi_done, pi_err, ram_oe_n, ram_we_n, bus_data_oe}, 5'b00110);
        chk("reset_data", {bus_addr, bus_data_out, pi_rd_data}, 33'h0);
        reset_n = 1'b1;
        tick();

        for (int n = 0; n < 5; n++) begin
            do_access(vecs[n]);
        end

        // Abort: pending withdrawn while waiting; a late bus_slot must not start an access.
        pi_rw_b    = 1'b0;
        pi_addr    = 17'h0BEEF;
        pi_data_in = 8'h99;
        pi_pending = 1'b1;
        repeat (4) tick();
        pi_pending = 1'b0;
        cnt = 0;
        for (int i = 1; i <= 14; i++) begin
            bus_slot = (i == 5);
            tick();
            if (!ram_oe_n || !ram_we_n || bus_data_oe || pi_done) cnt++;
        end
        bus_slot = 1'b0;
        chk("abort_no_access", cnt, 0);
        chk("abort_addr_unchanged", bus_addr, 17'h00001);
        v = '{rw: 1'b1, addr: 17'h00F0F, wd: 8'h00, bin: 8'h96, dly: 6, hold: 0, exp_rd: 8'h96};
        do_access(v);

        // Asynchronous reset in the middle of a write strobe.
        pi_rw_b    = 1'b0;
        pi_addr    = 17'h0AAAA;
        pi_data_in = 8'h55;
        pi_pending = 1'b1;
        repeat (4) tick();
        bus_slot = 1'b1;
        tick();
        bus_slot = 1'b0;
        tick();
        chk("pre_reset_strobe", {ram_we_n, bus_data_oe}, 2'b01);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_ctl", {ram_oe_n, ram_we_n, bus_data_oe, pi_done}, 4'b1100);
        chk("async_reset_data", {bus_addr, pi_rd_data}, 25'h0);
        pi_pending = 1'b0;
        tick();
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (!ram_oe_n || !ram_we_n || bus_data_oe || pi_done) cnt++;
        end
        chk("post_reset_idle", cnt, 0);

        // Slot never granted.
        pi_rw_b    = 1'b1;
        pi_addr    = 17'h01234;
        pi_pending = 1'b1;
`ifdef PI_BUS_TIMEOUT_EN
        cnt = 0;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (pi_done || !ram_oe_n || !ram_we_n) cnt++;
        end
        chk("timeout_not_early", cnt, 0);
        tick();
        chk("timeout_done_err", {pi_done, pi_err, ram_oe_n, ram_we_n}, 4'b1111);
        chk("timeout_rd_unchanged", pi_rd_data, 8'h00);
        pi_pending = 1'b0;
        repeat (3) tick();
        chk("timeout_clear", {pi_done, pi_err}, 2'b00);
`else
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (pi_done || pi_err || !ram_oe_n || !ram_we_n) cnt++;
        end
        chk("no_timeout_waiting", cnt, 0);
        pi_pending = 1'b0;
        repeat (4) tick();
        chk("no_timeout_idle", {pi_done, pi_err}, 2'b00);
`endif

        chk("bus_invariants", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
